// File: rtl/shift_issue_stage.sv
// Decode-and-issue stage feeding the barrel shifter: decodes MIPS32r2 SPECIAL shift/rotate
// instructions into {data, amount, op, rd} and buffers them in a 2-entry FIFO with valid/ready.
module shift_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_amount,
    output logic [2:0]  out_op,
    output logic [4:0]  out_rd,
    output logic        o_reject
);

    typedef enum logic [2:0] {
        OP_SLL = 3'b001,
        OP_SRL = 3'b010,
        OP_SRA = 3'b100,
        OP_ROR = 3'b110
    } shift_op_e;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  amount;
        logic [2:0]  op;
        logic [4:0]  rd;
    } entry_t;

    entry_t     head_q, tail_q, dec_entry;
    logic [1:0] count_q;
    logic       dec_legal;
    shift_op_e  dec_op;
    logic [4:0] dec_amount;
    logic       accept, push, pop;

    // The rt field is implied by in_rt_data and only the low 5 bits of rs form an amount.
    logic unused_bits;
    assign unused_bits = ^{in_rs_data[31:5], in_instr[20:16]};

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        dec_legal  = 1'b0;
        dec_op     = OP_SLL;
        dec_amount = in_instr[10:6];
        if (in_instr[31:26] == '0) begin
            case (in_instr[5:0])
                6'b000000: dec_legal = (in_instr[25:21] == '0);
                6'b000010: begin
                    dec_legal = (in_instr[25:22] == '0);
                    dec_op    = in_instr[21] ? OP_ROR : OP_SRL;
                end
                6'b000011: begin
                    dec_legal = (in_instr[25:21] == '0);
                    dec_op    = OP_SRA;
                end
                6'b000100: begin
                    dec_legal  = (in_instr[10:6] == '0);
                    dec_amount = in_rs_data[4:0];
                end
                6'b000110: begin
                    dec_legal  = (in_instr[10:7] == '0);
                    dec_op     = in_instr[6] ? OP_ROR : OP_SRL;
                    dec_amount = in_rs_data[4:0];
                end
                6'b000111: begin
                    dec_legal  = (in_instr[10:6] == '0);
                    dec_op     = OP_SRA;
                    dec_amount = in_rs_data[4:0];
                end
                default: dec_legal = 1'b0;
            endcase
        end
        dec_entry = '{data: in_rt_data, amount: dec_amount, op: dec_op, rd: in_instr[15:11]};
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid & in_ready & ~flush;
    assign push      = accept & dec_legal;
    assign pop       = out_valid & out_ready & ~flush;

    // NOTE: entry storage is reset as well because the output fields must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            head_q   <= '0;
            tail_q   <= '0;
            o_reject <= 1'b0;
        end else if (flush) begin
            count_q  <= 2'd0;
            o_reject <= 1'b0;
        end else begin
            o_reject <= accept & ~dec_legal;
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= dec_entry;
                    else                 tail_q <= dec_entry;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    // With one entry left the head simply holds its last value.
                    if (count_q == 2'd2) head_q <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                // Push implies count<2 and pop implies count>0, so both means count==1.
                2'b11: head_q <= dec_entry;
                default: ;
            endcase
        end
    end

    assign out_data   = head_q.data;
    assign out_amount = head_q.amount;
    assign out_op     = head_q.op;
    assign out_rd     = head_q.rd;

endmodule
